// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: OPID codes, opcode match table and fetch FSM states.
package cpu_pkg;

  localparam logic [3:0] OPID_NONE  = 4'b0000;
  localparam logic [3:0] OPID_ADDI  = 4'b0001;
  localparam logic [3:0] OPID_ADDS  = 4'b0010;
  localparam logic [3:0] OPID_B     = 4'b0011;
  localparam logic [3:0] OPID_BCOND = 4'b0100;
  localparam logic [3:0] OPID_BL    = 4'b0101;
  localparam logic [3:0] OPID_BR    = 4'b0110;
  localparam logic [3:0] OPID_CBZ   = 4'b0111;
  localparam logic [3:0] OPID_LDUR  = 4'b1000;
  localparam logic [3:0] OPID_STUR  = 4'b1001;
  localparam logic [3:0] OPID_SUBS  = 4'b1010;

  // Opcode field masks, by the width of the opcode field anchored at bit 31.
  localparam logic [31:0] MASK_OP6  = 32'hFC00_0000;
  localparam logic [31:0] MASK_OP8  = 32'hFF00_0000;
  localparam logic [31:0] MASK_OP10 = 32'hFFC0_0000;
  localparam logic [31:0] MASK_OP11 = 32'hFFE0_0000;

  typedef struct packed {
    logic [31:0] mask;
    logic [31:0] match;
    logic [3:0]  opid;
  } opid_pattern_t;

  localparam int unsigned NUM_PATTERNS = 10;

  // Ordered by priority: lower index wins when several patterns match.
  localparam opid_pattern_t OPID_TABLE [NUM_PATTERNS] = '{
    '{mask: MASK_OP10, match: 32'h9100_0000, opid: OPID_ADDI},
    '{mask: MASK_OP11, match: 32'hAB00_0000, opid: OPID_ADDS},
    '{mask: MASK_OP6,  match: 32'h1400_0000, opid: OPID_B},
    '{mask: MASK_OP8,  match: 32'h5400_0000, opid: OPID_BCOND},
    '{mask: MASK_OP6,  match: 32'h9400_0000, opid: OPID_BL},
    '{mask: MASK_OP11, match: 32'hD600_0000, opid: OPID_BR},
    '{mask: MASK_OP8,  match: 32'hB400_0000, opid: OPID_CBZ},
    '{mask: MASK_OP11, match: 32'hF840_0000, opid: OPID_LDUR},
    '{mask: MASK_OP11, match: 32'hF800_0000, opid: OPID_STUR},
    '{mask: MASK_OP11, match: 32'hEB00_0000, opid: OPID_SUBS}
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } fetch_state_t;

endpackage

// File: rtl/opid_classify.sv
// Combinational instruction-word classifier producing the 4-bit OPID used by decode.
module opid_classify
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  opid
);

  // Walk the table backwards so the lowest-index match is the one left standing.
  always_comb begin
    opid = OPID_NONE;
    for (int i = NUM_PATTERNS - 1; i >= 0; i--) begin
      if ((instr & OPID_TABLE[i].mask) == OPID_TABLE[i].match) begin
        opid = OPID_TABLE[i].opid;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single outstanding imem request, IF/ID register with stall,
// a one-entry hold buffer for words that arrive while decode is stalled, and redirect flush.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [3:0]        if_opid
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  logic              if_valid_q, if_valid_d;
  logic [31:0]       if_instr_q, if_instr_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [3:0]        if_opid_q, if_opid_d;

  // Hold buffer occupancy is implied by state_q == S_HOLD.
  logic [31:0]       hold_instr_q, hold_instr_d;
  logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
  logic [3:0]        hold_opid_q, hold_opid_d;

  logic [3:0]        rsp_opid;
  logic              slot_free;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] redirect_tgt;

  opid_classify u_opid_classify (
    .instr (imem_rsp_data),
    .opid  (rsp_opid)
  );

  assign slot_free    = !if_valid_q || !stall;
  assign pc_next      = pc_q + ADDR_W'(4);
  assign redirect_tgt = redirect_pc & ~ADDR_W'(3);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    // A consumed instruction drops out unless something new is loaded below.
    if_valid_d   = if_valid_q && stall;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    if_opid_d    = if_opid_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    hold_opid_d  = hold_opid_q;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (redirect_valid) begin
          // A request accepted alongside a redirect targets the old PC; drain its response.
          state_d = imem_req_ready ? S_DRAIN : S_REQ;
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
        end else if (imem_rsp_valid) begin
          pc_d = pc_next;
          if (slot_free) begin
            if_valid_d = 1'b1;
            if_instr_d = imem_rsp_data;
            if_pc_d    = pc_q;
            if_opid_d  = rsp_opid;
            state_d    = S_REQ;
          end else begin
            hold_instr_d = imem_rsp_data;
            hold_pc_d    = pc_q;
            hold_opid_d  = rsp_opid;
            state_d      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          state_d = S_REQ;
        end else if (slot_free) begin
          if_valid_d = 1'b1;
          if_instr_d = hold_instr_q;
          if_pc_d    = hold_pc_q;
          if_opid_d  = hold_opid_q;
          state_d    = S_REQ;
        end
      end
      S_DRAIN: begin
        if (imem_rsp_valid) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Redirect overrides stall and any response in the same cycle.
    if (redirect_valid) begin
      pc_d       = redirect_tgt;
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
      if_opid_q    <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      hold_opid_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      if_opid_q    <= if_opid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      hold_opid_q  <= hold_opid_d;
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign if_valid       = if_valid_q;
  assign if_instr       = if_instr_q;
  assign if_pc          = if_pc_q;
  assign if_opid        = if_opid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected IF/ID entries are queued as words are issued and a
// monitor pops them whenever decode consumes an instruction (if_valid && !stall).
`timescale 1ns/1ps
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid, req_ready, rsp_valid, stall, redirect_valid;
  logic [63:0] req_addr, redirect_pc, if_pc;
  logic [31:0] rsp_data, if_instr;
  logic        if_valid;
  logic [3:0]  if_opid;

  logic        w_req_valid, w_rsp_valid, w_if_valid;
  logic [63:0] w_req_addr, w_if_pc;
  logic [31:0] w_if_instr;
  logic [3:0]  w_if_opid;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req_valid (req_valid),
    .imem_req_addr  (req_addr),
    .imem_req_ready (req_ready),
    .imem_rsp_valid (rsp_valid),
    .imem_rsp_data  (rsp_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_opid        (if_opid)
  );

  fetch_unit #(.ADDR_W(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req_valid (w_req_valid),
    .imem_req_addr  (w_req_addr),
    .imem_req_ready (1'b1),
    .imem_rsp_valid (w_rsp_valid),
    .imem_rsp_data  (32'h9100_0421),
    .stall          (1'b0),
    .redirect_valid (1'b0),
    .redirect_pc    (64'h0),
    .if_valid       (w_if_valid),
    .if_instr       (w_if_instr),
    .if_pc          (w_if_pc),
    .if_opid        (w_if_opid)
  );

  // Always-ready memory for the wrap instance: answers one cycle after each accept.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) w_rsp_valid <= 1'b0;
    else          w_rsp_valid <= w_req_valid && !w_rsp_valid;
  end

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [3:0]  opid;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_entry(input logic [31:0] w, input logic [63:0] pc, input logic [3:0] op);
    exp_t e;
    e.instr = w;
    e.pc    = pc;
    e.opid  = op;
    sb.push_back(e);
  endtask

  task automatic accept(input logic [63:0] exp_addr, input string name);
    int n = 0;
    req_ready = 1'b1;
    while (!req_valid && n < 20) begin
      step();
      n++;
    end
    check({name, "_req_valid"}, {63'd0, req_valid}, 64'd1);
    check({name, "_req_addr"}, req_addr, exp_addr);
    step();
    req_ready = 1'b0;
  endtask

  task automatic respond(input logic [31:0] w);
    rsp_valid = 1'b1;
    rsp_data  = w;
    step();
    rsp_valid = 1'b0;
    rsp_data  = '0;
  endtask

  // Monitor: decode consumes the IF/ID entry whenever it is valid and not stalled.
  always @(negedge clk) begin
    if (reset_n && if_valid && !stall) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL ifid_unexpected: got instr %h pc %h opid %h, none queued",
                 if_instr, if_pc, if_opid);
      end else begin
        mon_e = sb.pop_front();
        if (if_instr !== mon_e.instr || if_pc !== mon_e.pc || if_opid !== mon_e.opid) begin
          errors++;
          $display("FAIL ifid_entry: got instr %h pc %h opid %h expected instr %h pc %h opid %h",
                   if_instr, if_pc, if_opid, mon_e.instr, mon_e.pc, mon_e.opid);
        end
      end
    end
  end

  // Bench protocol guard: responses only while a request is outstanding.
  always @(negedge clk) begin
    if (reset_n && rsp_valid) begin
      checks++;
      if (dut.state_q inside {S_IDLE, S_REQ, S_HOLD}) begin
        errors++;
        $display("FAIL rsp_protocol: rsp_valid in state %0d, required WAIT or DRAIN",
                 dut.state_q);
      end
    end
  end

  initial begin : wrap_checks
    int n;
    wait (reset_n === 1'b1);
    n = 0;
    while (!w_req_valid && n < 10) begin
      step();
      n++;
    end
    check("wrap_first_valid", {63'd0, w_req_valid}, 64'd1);
    check("wrap_first_addr", w_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    step();
    check("wrap_if_valid", {63'd0, w_if_valid}, 64'd1);
    check("wrap_if_pc", w_if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_if_opid", {60'd0, w_if_opid}, {60'd0, OPID_ADDI});
    check("wrap_second_valid", {63'd0, w_req_valid}, 64'd1);
    check("wrap_second_addr", w_req_addr, 64'h0);
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  logic [31:0] stream_w [5];
  logic [3:0]  stream_op [5];

  initial begin : main
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    rsp_data       = '0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stream_w  = '{32'h1400_0003, 32'hF840_0000, 32'hF800_0000, 32'hEB02_0020, 32'h0000_0000};
    stream_op = '{OPID_B, OPID_LDUR, OPID_STUR, OPID_SUBS, OPID_NONE};

    // Reset state.
    step();
    step();
    check("rst_req_valid", {63'd0, req_valid}, 64'd0);
    check("rst_req_addr", req_addr, 64'h0);
    check("rst_if_valid", {63'd0, if_valid}, 64'd0);
    check("rst_if_instr", {32'd0, if_instr}, 64'd0);
    check("rst_if_pc", if_pc, 64'h0);
    check("rst_if_opid", {60'd0, if_opid}, 64'd0);
    reset_n = 1'b1;

    // First fetch: ADDI at pc 0, next request at 4.
    accept(64'h0, "p1a");
    expect_entry(32'h9100_0421, 64'h0, OPID_ADDI);
    respond(32'h9100_0421);
    check("p1_next_addr", req_addr, 64'h4);

    // Back to 0 and stream five words at full throughput.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      accept(64'(4 * i), "p2");
      expect_entry(stream_w[i], 64'(4 * i), stream_op[i]);
      respond(stream_w[i]);
    end

    // Memory back-pressure: address held at 8 for three cycles, accepted on the fourth.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("p3_hold_valid", {63'd0, req_valid}, 64'd1);
      check("p3_hold_addr", req_addr, 64'h8);
      step();
    end
    accept(64'h8, "p3a");
    expect_entry(32'h5400_0040, 64'h8, OPID_BCOND);
    respond(32'h5400_0040);

    // Stall: second word parks in the hold buffer until decode frees the slot.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0;
    step();
    redirect_valid = 1'b0;
    accept(64'h0, "p4a");
    expect_entry(32'h9400_0010, 64'h0, OPID_BL);
    stall = 1'b1;
    respond(32'h9400_0010);
    accept(64'h4, "p4b");
    expect_entry(32'hD61F_0000, 64'h4, OPID_BR);
    respond(32'hD61F_0000);
    check("p4_stall_instr", {32'd0, if_instr}, 64'h9400_0010);
    check("p4_stall_pc", if_pc, 64'h0);
    check("p4_stall_noreq", {63'd0, req_valid}, 64'd0);
    step();
    check("p4_stall_noreq2", {63'd0, req_valid}, 64'd0);
    check("p4_stall_valid", {63'd0, if_valid}, 64'd1);
    stall = 1'b0;
    step();
    check("p4_release_pc", if_pc, 64'h4);
    check("p4_release_req_valid", {63'd0, req_valid}, 64'd1);
    check("p4_release_req_addr", req_addr, 64'h8);

    // Redirect in WAIT flushes a stalled IF/ID entry and drains the stale response.
    accept(64'h8, "p5a");
    stall = 1'b1;
    respond(32'hB400_0041);
    accept(64'hC, "p5b");
    redirect_valid = 1'b1;
    redirect_pc    = 64'h103;
    step();
    redirect_valid = 1'b0;
    check("p5_flush_valid", {63'd0, if_valid}, 64'd0);
    check("p5_drain_noreq", {63'd0, req_valid}, 64'd0);
    stall = 1'b0;
    respond(32'hDEAD_BEEF);
    check("p5_drain_discard", {63'd0, if_valid}, 64'd0);
    accept(64'h100, "p5c");
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h200;
    rsp_valid      = 1'b1;
    rsp_data       = 32'h9100_0421;
    step();
    stall          = 1'b0;
    redirect_valid = 1'b0;
    rsp_valid      = 1'b0;
    rsp_data       = '0;
    check("p5_redir_drop_valid", {63'd0, if_valid}, 64'd0);
    check("p5_redir_req_valid", {63'd0, req_valid}, 64'd1);
    check("p5_redir_req_addr", req_addr, 64'h200);
    accept(64'h200, "p5d");
    expect_entry(32'hAB00_0020, 64'h200, OPID_ADDS);
    respond(32'hAB00_0020);

    // Asynchronous reset mid-WAIT.
    accept(64'h204, "p6a");
    reset_n = 1'b0;
    #1;
    check("p6_rst_if_valid", {63'd0, if_valid}, 64'd0);
    check("p6_rst_if_instr", {32'd0, if_instr}, 64'd0);
    check("p6_rst_if_pc", if_pc, 64'h0);
    check("p6_rst_if_opid", {60'd0, if_opid}, 64'd0);
    check("p6_rst_req_valid", {63'd0, req_valid}, 64'd0);
    check("p6_rst_req_addr", req_addr, 64'h0);
    step();
    step();
    reset_n = 1'b1;
    accept(64'h0, "p6b");
    expect_entry(32'h9100_0421, 64'h0, OPID_ADDI);
    respond(32'h9100_0421);
    step();
    step();

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
